// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell; purely combinational, shared by the serial controller.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of one bit position.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fa cell resolves one bit per clock, LSB first, with the
// ripple carry held in a register between cycles.
//
// Request/response: start is sampled only while idle; the edge that sees it
// captures op_a, op_b and cin_in. busy is high for the WIDTH bit cycles, then
// done pulses for exactly one cycle with sum/cout valid. sum/cout stay stable
// until the next accepted start. start seen while busy or done is dropped,
// never queued.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    assign last_bit = (cnt == LAST_BIT);

    fa u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // State register; reset drops any in-flight operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are plain decodes of the state register, so never both high.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand shifters, carry, bit counter and result assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= op_a;
                        sh_b  <= op_b;
                        carry <= cin_in;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                RUN: begin
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    // The counter parks on the last bit rather than wrapping;
                    // it is reloaded on the next accepted start.
                    if (last_bit) begin
                        cout <= fa_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
